// File: rtl/bandpass_sweep_pkg.sv
// Shared types and default widths for the bandpass characterisation sweep controller.
package bandpass_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_ACQ,
    ST_REPORT
  } sweep_state_e;

  localparam int FW_DEFAULT   = 16;
  localparam int DW_DEFAULT   = 12;
  localparam int NLOG_DEFAULT = 4;
  localparam int SW_DEFAULT   = 16;

  // Sum of 2^nlog samples of dw bits always fits in dw+nlog bits.
  function automatic int acc_width(input int dw, input int nlog);
    return dw + nlog;
  endfunction

endpackage

// File: rtl/sweep_averager.sv
// Accumulates 2^NLOG detector samples per sweep point and presents their truncated mean.
module sweep_averager
  import bandpass_sweep_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NLOG = NLOG_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          accept_i,
  input  logic [DW-1:0] sample_i,
  output logic          last_sample_o,
  output logic [DW-1:0] avg_o
);

  localparam int AW = acc_width(DW, NLOG);

  logic [AW-1:0]   acc_q, acc_d;
  logic [NLOG-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept_i) begin
      acc_d = acc_q + AW'(sample_i);
      cnt_d = cnt_q + NLOG'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // The sample counter wraps to zero on the final accept, so all-ones marks the last one.
  assign last_sample_o = accept_i && !clear_i && (cnt_q == '1);
  assign avg_o         = acc_q[AW-1:NLOG];

endmodule

// File: rtl/bandpass_sweep_ctrl.sv
// Frequency sweep sequencer: steps the DDS word, waits for settling, averages the detector
// and hands each (frequency, magnitude) pair to the host.
module bandpass_sweep_ctrl
  import bandpass_sweep_pkg::*;
#(
  parameter int FW   = FW_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int NLOG = NLOG_DEFAULT,
  parameter int SW   = SW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [FW-1:0] f_start_i,
  input  logic [FW-1:0] f_stop_i,
  input  logic [FW-1:0] f_step_i,
  input  logic [SW-1:0] settle_cycles_i,
  output logic [FW-1:0] freq_word_o,
  output logic          freq_load_o,
  input  logic          smp_valid_i,
  input  logic [DW-1:0] smp_data_i,
  output logic          smp_ready_o,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [FW-1:0] res_freq_o,
  output logic [DW-1:0] res_mag_o,
  output logic          busy_o,
  output logic          done_o
);

  sweep_state_e  state_q, state_d;
  logic [FW-1:0] cur_q, cur_d;
  logic [FW-1:0] stop_q, stop_d;
  logic [FW-1:0] step_q, step_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic          accept;
  logic          avg_clear;
  logic          last_sample;
  logic [DW-1:0] avg;
  logic [FW:0]   next_sum;
  logic          last_point;

  assign accept     = smp_valid_i && (state_q == ST_ACQ);
  assign avg_clear  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign next_sum   = {1'b0, cur_q} + {1'b0, step_q};
  assign last_point = (step_q == '0) || next_sum[FW] || (next_sum[FW-1:0] > stop_q);

  sweep_averager #(
    .DW   (DW),
    .NLOG (NLOG)
  ) u_avg (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (avg_clear),
    .accept_i      (accept),
    .sample_i      (smp_data_i),
    .last_sample_o (last_sample),
    .avg_o         (avg)
  );

  // Abort only matters once a sweep is running, so start always wins in IDLE.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stop_d   = stop_q;
    step_d   = step_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (state_q != ST_IDLE && abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cur_d    = f_start_i;
            stop_d   = f_stop_i;
            step_d   = f_step_i;
            settle_d = settle_cycles_i;
            state_d  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_d   = settle_q;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_ACQ;
          else cnt_d = cnt_q - SW'(1);
        end
        ST_ACQ: begin
          if (last_sample) state_d = ST_REPORT;
        end
        ST_REPORT: begin
          if (res_ready_i) begin
            if (last_point) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cur_d   = next_sum[FW-1:0];
              state_d = ST_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // The current point register doubles as the DDS word, so it holds across abort.
  assign freq_word_o = cur_q;
  assign freq_load_o = (state_q == ST_LOAD);
  assign smp_ready_o = (state_q == ST_ACQ);
  assign res_valid_o = (state_q == ST_REPORT);
  assign res_freq_o  = (state_q == ST_REPORT) ? cur_q : '0;
  assign res_mag_o   = (state_q == ST_REPORT) ? avg : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_bandpass_sweep_ctrl.sv
// Directed scoreboard bench for bandpass_sweep_ctrl.
module tb_bandpass_sweep_ctrl;

  typedef struct {
    logic [15:0] freq;
    logic [11:0] mag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] fStart;
  logic [15:0] fStop;
  logic [15:0] fStep;
  logic [15:0] settle;
  logic [15:0] freqWord;
  logic        freqLoad;
  wire         smpValid;
  wire  [11:0] smpData;
  logic        smpReady;
  logic        resValid;
  logic        resReady;
  logic [15:0] resFreq;
  logic [11:0] resMag;
  logic        busy;
  logic        done;

  logic        validEn;
  logic        gapMode;
  logic        altMode;
  logic [11:0] constVal;
  int          cyc;
  int          smpIdx;

  int          vecs;
  int          errs;
  int          loadCnt;
  int          doneCnt;
  int          acceptCnt;
  logic        prevResValid;
  int          loadCycles[$];
  logic [15:0] loadFreqs[$];
  exp_t        sb[$];

  bandpass_sweep_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .abort_i         (abort),
    .f_start_i       (fStart),
    .f_stop_i        (fStop),
    .f_step_i        (fStep),
    .settle_cycles_i (settle),
    .freq_word_o     (freqWord),
    .freq_load_o     (freqLoad),
    .smp_valid_i     (smpValid),
    .smp_data_i      (smpData),
    .smp_ready_o     (smpReady),
    .res_valid_o     (resValid),
    .res_ready_i     (resReady),
    .res_freq_o      (resFreq),
    .res_mag_o       (resMag),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (smpValid && smpReady) smpIdx <= smpIdx + 1;
  end

  assign smpValid = validEn && (!gapMode || (cyc % 3 != 0));
  assign smpData  = altMode ? (smpIdx[0] ? 12'h002 : 12'h001) : constVal;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushSweep(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st,
                           input logic [11:0] mag);
    logic [16:0] nx;
    logic [15:0] c;
    exp_t        e;
    c = fs;
    for (int i = 0; i < 64; i++) begin
      e.freq = c;
      e.mag  = mag;
      sb.push_back(e);
      nx = {1'b0, c} + {1'b0, st};
      if (st == 16'd0 || nx[16] || nx[15:0] > fe) break;
      c = nx[15:0];
    end
  endtask

  task automatic applyStimulus(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st,
                               input logic [15:0] stl, output int startCyc);
    fStart   = fs;
    fStop    = fe;
    fStep    = st;
    settle   = stl;
    start    = 1'b1;
    startCyc = cyc;
    tick(1);
    start    = 1'b0;
  endtask

  // which: 0 done, 1 res_valid, 2 smp_ready, 3 load count reaches target
  task automatic waitCond(input string tag, input int which, input int target, input int maxc);
    int seen;
    seen = 0;
    for (int i = 0; i < maxc && seen == 0; i++) begin
      @(negedge clk);
      case (which)
        0: if (done) seen = 1;
        1: if (resValid) seen = 1;
        2: if (smpReady) seen = 1;
        default: if (loadCnt >= target) seen = 1;
      endcase
    end
    checkOutput(tag, seen, 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_freq_word"}, freqWord, 0);
    checkOutput({tag, "_freq_load"}, freqLoad, 0);
    checkOutput({tag, "_smp_ready"}, smpReady, 0);
    checkOutput({tag, "_res_valid"}, resValid, 0);
    checkOutput({tag, "_res_freq"}, resFreq, 0);
    checkOutput({tag, "_res_mag"}, resMag, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (freqLoad) begin
        loadCnt++;
        loadCycles.push_back(cyc);
        loadFreqs.push_back(freqWord);
        acceptCnt = 0;
      end
      if (done) doneCnt++;
      if (done || freqLoad) checkOutput("done_load_exclusive", done && freqLoad, 0);
      if (smpValid && smpReady) acceptCnt++;
      if (resValid && !prevResValid) checkOutput("samples_per_point", acceptCnt, 16);
      if (resValid && resReady && !abort) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("res_freq", resFreq, e.freq);
          checkOutput("res_mag", resMag, e.mag);
        end
      end
      prevResValid = resValid;
    end
  endtask

  initial begin
    int sc;
    int b;
    int l0;
    int d0;
    int accC;
    vecs = 0; errs = 0; loadCnt = 0; doneCnt = 0; acceptCnt = 0; prevResValid = 1'b0;
    cyc = 0; smpIdx = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; resReady = 1'b1;
    fStart = '0; fStop = '0; fStep = '0; settle = '0;
    validEn = 1'b1; gapMode = 1'b0; altMode = 1'b0; constVal = 12'h800;
    fork
      monitorLoop();
      begin
        tick(3);
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick(2);

        $display("[TB] basic sweep 100..400 step 100");
        b = loadCycles.size(); d0 = doneCnt;
        pushSweep(16'd100, 16'd400, 16'd100, 12'h800);
        applyStimulus(16'd100, 16'd400, 16'd100, 16'd3, sc);
        waitCond("basic_done", 0, 0, 200);
        tick(2);
        checkOutput("basic_loads", loadCycles.size() - b, 4);
        checkOutput("basic_start_latency", loadCycles[b] - sc, 1);
        for (int k = 0; k < 3; k++)
          checkOutput("basic_point_period", loadCycles[b+k+1] - loadCycles[b+k], 22);
        for (int k = 0; k < 4; k++)
          checkOutput("basic_freq_word", loadFreqs[b+k], 100 * (k + 1));
        checkOutput("basic_done_count", doneCnt - d0, 1);
        checkOutput("basic_sb_empty", sb.size(), 0);
        checkOutput("basic_idle", busy, 0);

        $display("[TB] truncating average, single point");
        altMode = 1'b1; d0 = doneCnt;
        pushSweep(16'd700, 16'd900, 16'd0, 12'h001);
        applyStimulus(16'd700, 16'd900, 16'd0, 16'd0, sc);
        waitCond("trunc_done", 0, 0, 100);
        tick(2);
        checkOutput("trunc_sb_empty", sb.size(), 0);
        checkOutput("trunc_done_count", doneCnt - d0, 1);
        altMode = 1'b0; constVal = 12'h3A5;

        $display("[TB] range edges");
        l0 = loadCnt;
        pushSweep(16'hFFF0, 16'hFFFF, 16'h0010, 12'h3A5);
        applyStimulus(16'hFFF0, 16'hFFFF, 16'h0010, 16'd1, sc);
        waitCond("carry_done", 0, 0, 100);
        tick(2);
        checkOutput("carry_single_point", loadCnt - l0, 1);
        checkOutput("carry_sb_empty", sb.size(), 0);
        l0 = loadCnt;
        pushSweep(16'd500, 16'd100, 16'd50, 12'h3A5);
        applyStimulus(16'd500, 16'd100, 16'd50, 16'd1, sc);
        waitCond("inverted_done", 0, 0, 100);
        tick(2);
        checkOutput("inverted_single_point", loadCnt - l0, 1);
        checkOutput("inverted_sb_empty", sb.size(), 0);
        b = loadFreqs.size();
        pushSweep(16'd100, 16'd350, 16'd100, 12'h3A5);
        applyStimulus(16'd100, 16'd350, 16'd100, 16'd0, sc);
        waitCond("inexact_done", 0, 0, 200);
        tick(2);
        checkOutput("inexact_points", loadFreqs.size() - b, 3);
        checkOutput("inexact_last_freq", loadFreqs[b+2], 300);
        checkOutput("inexact_sb_empty", sb.size(), 0);

        $display("[TB] backpressure and sample gaps");
        resReady = 1'b0; constVal = 12'h123;
        b = loadCycles.size();
        pushSweep(16'd10, 16'd20, 16'd10, 12'h123);
        applyStimulus(16'd10, 16'd20, 16'd10, 16'd2, sc);
        waitCond("bp_res_valid", 1, 0, 100);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checkOutput("bp_valid_hold", resValid, 1);
          checkOutput("bp_freq_hold", resFreq, 10);
          checkOutput("bp_mag_hold", resMag, 12'h123);
        end
        tick(1);
        checkOutput("bp_no_reload", loadCycles.size() - b, 1);
        resReady = 1'b1; gapMode = 1'b1; accC = cyc;
        waitCond("bp_done", 0, 0, 300);
        tick(2);
        checkOutput("bp_reload_latency", loadCycles[b+1] - accC, 1);
        checkOutput("bp_sb_empty", sb.size(), 0);
        gapMode = 1'b0;

        $display("[TB] abort during settle of second point");
        constVal = 12'h0F0; l0 = loadCnt;
        pushSweep(16'd1000, 16'd1000, 16'd0, 12'h0F0);
        applyStimulus(16'd1000, 16'd4000, 16'd1000, 16'd20, sc);
        waitCond("abort_second_load", 3, l0 + 2, 200);
        tick(5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_smp_ready", smpReady, 0);
        checkOutput("abort_res_valid", resValid, 0);
        l0 = loadCnt; d0 = doneCnt;
        tick(60);
        checkOutput("abort_no_load", loadCnt - l0, 0);
        checkOutput("abort_no_done", doneCnt - d0, 0);
        checkOutput("abort_freq_hold", freqWord, 2000);
        checkOutput("abort_first_delivered", sb.size(), 0);

        $display("[TB] abort coincident with res_ready");
        resReady = 1'b0;
        pushSweep(16'd50, 16'd60, 16'd10, 12'h0F0);
        applyStimulus(16'd50, 16'd60, 16'd10, 16'd1, sc);
        waitCond("abort_rdy_res_valid", 1, 0, 100);
        tick(1);
        abort = 1'b1; resReady = 1'b1;
        tick(1);
        abort = 1'b0;
        checkOutput("abort_rdy_busy", busy, 0);
        checkOutput("abort_rdy_res_valid", resValid, 0);
        l0 = loadCnt; d0 = doneCnt;
        tick(30);
        checkOutput("abort_rdy_not_delivered", sb.size(), 2);
        checkOutput("abort_rdy_no_done", doneCnt - d0, 0);
        checkOutput("abort_rdy_no_load", loadCnt - l0, 0);
        sb.delete();
        b = loadFreqs.size();
        pushSweep(16'd7, 16'd7, 16'd1, 12'h0F0);
        applyStimulus(16'd7, 16'd7, 16'd1, 16'd0, sc);
        waitCond("restart_done", 0, 0, 100);
        tick(2);
        checkOutput("restart_freq", loadFreqs[b], 7);
        checkOutput("restart_sb_empty", sb.size(), 0);

        $display("[TB] asynchronous reset mid-acquisition");
        constVal = 12'h456;
        pushSweep(16'd300, 16'd600, 16'd100, 12'h456);
        applyStimulus(16'd300, 16'd600, 16'd100, 16'd2, sc);
        waitCond("rst_reach_acq", 2, 0, 100);
        tick(5);
        #3 rst = 1'b1;
        #1 checkIdleOutputs("async_rst");
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        tick(2);
        d0 = doneCnt;
        pushSweep(16'd300, 16'd500, 16'd100, 12'h456);
        applyStimulus(16'd300, 16'd500, 16'd100, 16'd2, sc);
        waitCond("post_rst_done", 0, 0, 300);
        tick(2);
        checkOutput("post_rst_done_count", doneCnt - d0, 1);
        checkOutput("post_rst_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
      end
    join
  end

endmodule
